// File: rtl/z80_bus_bridge.sv
// ---------------------------------------------------------------------------
// z80_bus_bridge
//
// Purpose:
//   Sits on the external pins of a Z80-compatible CPU and turns every memory,
//   I/O or interrupt-acknowledge machine cycle into at most one
//   request/acknowledge transaction on a simple synchronous system bus.
//   The CPU is stretched with nWAIT while the slave works. Read data and
//   interrupt vectors are returned on the CPU data pins. A transaction the
//   slave never answers is aborted after TIMEOUT request cycles and flagged
//   on the sticky bus_err output.
//
// Parameters:
//   TIMEOUT     request cycles allowed without bus_ack before abort (2..255)
//
// Ports:
//   CLK         system clock, everything happens on the rising edge
//   reset       synchronous, active-high
//   nM1, nMREQ, nIORQ, nRD, nWR, nRFSH
//               CPU control strobes, active-low, sampled on CLK
//   A           CPU address pins
//   D_in        data pins as driven by the CPU (write data)
//   D_out       data returned to the CPU (read data / vector / 0xFF on abort)
//   D_oe        when high the board drives D_out onto the CPU data pins
//   nWAIT       wait request to the CPU, active-low
//   bus_req     transaction request, held until ack or timeout
//   bus_we      1 = write, 0 = read
//   bus_io      1 = I/O space, 0 = memory space
//   bus_addr    transaction address
//   bus_wdata   transaction write data
//   bus_ack     slave completion (pulse or level), only looked at in REQ
//   bus_rdata   slave read data, valid while bus_ack is high
//   int_vector  vector handed to the CPU during interrupt acknowledge
//   bus_err     sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module z80_bus_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        nWAIT,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    input  logic [7:0]  int_vector,
    output logic        bus_err
);

    // The counter value at which an unanswered request gives up. The counter
    // starts at 0 on entry to REQ and is compared before incrementing, so the
    // request stays up for exactly TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [7:0]  counter;
    logic [7:0]  counterNext;

    logic [7:0]  doutNext;
    logic        doeNext;
    logic        nWaitNext;
    logic        reqNext;
    logic        weNext;
    logic        ioNext;
    logic [15:0] addrNext;
    logic [7:0]  wdataNext;
    logic        errNext;

    logic        refreshCycle;
    logic        startBus;
    logic        startWe;
    logic        startIo;
    logic        startIntAck;
    logic        strobesIdle;

    // Refresh cycles put a row address on the bus with nMREQ low; they must
    // never reach the system bus, so they are recognised first and block all
    // other decodes.
    assign refreshCycle = !nMREQ && !nRFSH;

    // HOLD can only end once the CPU has taken away every strobe that could
    // start a new cycle; nM1 and nRFSH alone never start one.
    assign strobesIdle = nMREQ && nIORQ && nRD && nWR;

    // Machine-cycle decode, evaluated every clock but only acted on in IDLE.
    // The order of the tests is the priority: interrupt acknowledge beats
    // I/O, I/O beats memory, and within a space a read beats a write so that
    // a glitch with nRD and nWR both low is handled as a harmless read.
    always_comb begin
        startBus    = 1'b0;
        startWe     = 1'b0;
        startIo     = 1'b0;
        startIntAck = 1'b0;
        if (!refreshCycle) begin
            if (!nIORQ && !nM1) begin
                startIntAck = 1'b1;
            end else if (!nIORQ && !nRD && nM1) begin
                startBus = 1'b1;
                startIo  = 1'b1;
            end else if (!nIORQ && !nWR) begin
                startBus = 1'b1;
                startIo  = 1'b1;
                startWe  = 1'b1;
            end else if (!nMREQ && !nRD && nRFSH) begin
                startBus = 1'b1;
            end else if (!nMREQ && !nWR && nRFSH) begin
                startBus = 1'b1;
                startWe  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic. Every output is a register, so the
    // defaults simply hold the current value; each state only lists what it
    // changes. In REQ the bus fields are never touched, which keeps address,
    // direction and write data stable for the whole request no matter what
    // the CPU pins do, and bus_req only falls on ack or timeout.
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        doutNext    = D_out;
        doeNext     = D_oe;
        nWaitNext   = nWAIT;
        reqNext     = bus_req;
        weNext      = bus_we;
        ioNext      = bus_io;
        addrNext    = bus_addr;
        wdataNext   = bus_wdata;
        errNext     = bus_err;

        case (state)
            IDLE: begin
                if (startBus) begin
                    addrNext    = A;
                    wdataNext   = D_in;
                    weNext      = startWe;
                    ioNext      = startIo;
                    reqNext     = 1'b1;
                    nWaitNext   = 1'b0;
                    counterNext = 8'd0;
                    stateNext   = REQ;
                end else if (startIntAck) begin
                    // The vector is answered locally, so the CPU is never
                    // stretched and the system bus stays quiet.
                    doutNext  = int_vector;
                    doeNext   = 1'b1;
                    stateNext = HOLD;
                end
            end

            REQ: begin
                if (bus_ack) begin
                    // Ack is checked before the timeout so that an answer in
                    // the very last allowed cycle still counts as good.
                    if (!bus_we) begin
                        doutNext = bus_rdata;
                    end
                    reqNext   = 1'b0;
                    nWaitNext = 1'b1;
                    doeNext   = ~bus_we;
                    stateNext = HOLD;
                end else if (counter == TIMEOUT_LAST) begin
                    // Give the CPU an all-ones byte, the same value an
                    // undriven pulled-up data bus would read as.
                    doutNext  = 8'hFF;
                    errNext   = 1'b1;
                    reqNext   = 1'b0;
                    nWaitNext = 1'b1;
                    doeNext   = ~bus_we;
                    stateNext = HOLD;
                end else begin
                    counterNext = counter + 8'd1;
                end
            end

            HOLD: begin
                // Keep returning data until the CPU ends its cycle; if the
                // strobes already went away during REQ this exits on the
                // first edge after completion.
                if (strobesIdle) begin
                    doeNext   = 1'b0;
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and output registers. Reset wins on any edge, including in the
    // middle of a request: bus_req simply drops without an ack and the slave
    // is expected to cope with that.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= 8'd0;
            D_out     <= 8'h00;
            D_oe      <= 1'b0;
            nWAIT     <= 1'b1;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_io    <= 1'b0;
            bus_addr  <= 16'h0000;
            bus_wdata <= 8'h00;
            bus_err   <= 1'b0;
        end else begin
            state     <= stateNext;
            counter   <= counterNext;
            D_out     <= doutNext;
            D_oe      <= doeNext;
            nWAIT     <= nWaitNext;
            bus_req   <= reqNext;
            bus_we    <= weNext;
            bus_io    <= ioNext;
            bus_addr  <= addrNext;
            bus_wdata <= wdataNext;
            bus_err   <= errNext;
        end
    end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_z80_bus_bridge
//
// Drives CPU machine cycles and slave responses into z80_bus_bridge built
// with TIMEOUT=4. For every cycle it issues, the stimulus works out what the
// bridge should do from the cycle type, the slave delay and the sticky error
// history, and queues it. A monitor watching the DUT at the falling edge
// pops and compares whenever a request starts, a request completes or an
// interrupt vector is presented.
// ---------------------------------------------------------------------------
module tb_z80_bus_bridge;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        reset;
    logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
    logic [15:0] A;
    logic [7:0]  D_in;
    logic [7:0]  D_out;
    logic        D_oe;
    logic        nWAIT;
    logic        bus_req, bus_we, bus_io;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic [7:0]  int_vector;
    logic        bus_err;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic        io;
        logic [7:0]  wdata;
    } reqT;

    typedef struct {
        int          len;
        logic [7:0]  dout;
        logic        doe;
        logic        err;
    } compT;

    reqT        reqQ[$];
    compT       compQ[$];
    logic [7:0] ackQ[$];

    int         compared   = 0;
    int         mismatched = 0;

    // Reference-model state: what the CPU last saw on D_out and whether a
    // timeout has happened since the last reset.
    logic       errModel  = 1'b0;
    logic [7:0] lastDout  = 8'h00;

    // Monitor bookkeeping.
    logic       prevReq = 1'b0;
    logic       prevOe  = 1'b0;
    int         reqLen  = 0;

    z80_bus_bridge #(.TIMEOUT(TO)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .nM1        (nM1),
        .nMREQ      (nMREQ),
        .nIORQ      (nIORQ),
        .nRD        (nRD),
        .nWR        (nWR),
        .nRFSH      (nRFSH),
        .A          (A),
        .D_in       (D_in),
        .D_out      (D_out),
        .D_oe       (D_oe),
        .nWAIT      (nWAIT),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_io     (bus_io),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .int_vector (int_vector),
        .bus_err    (bus_err)
    );

    always #5 CLK = ~CLK;

    // One comparison: counted always, reported only when it differs.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".nWAIT"},     nWAIT,     1);
        checkOutput({tag, ".D_oe"},      D_oe,      0);
        checkOutput({tag, ".D_out"},     D_out,     0);
        checkOutput({tag, ".bus_req"},   bus_req,   0);
        checkOutput({tag, ".bus_we"},    bus_we,    0);
        checkOutput({tag, ".bus_io"},    bus_io,    0);
        checkOutput({tag, ".bus_addr"},  bus_addr,  0);
        checkOutput({tag, ".bus_wdata"}, bus_wdata, 0);
        checkOutput({tag, ".bus_err"},   bus_err,   0);
    endtask

    task automatic releaseStrobes();
        nM1   = 1'b1;
        nMREQ = 1'b1;
        nIORQ = 1'b1;
        nRD   = 1'b1;
        nWR   = 1'b1;
        nRFSH = 1'b1;
    endtask

    // One CPU machine cycle. kind: 0 mem read, 1 mem write, 2 I/O read,
    // 3 I/O write, 4 interrupt ack, 5 refresh. delay is the edge (counted
    // from the decode edge) at which the slave acks; beyond TO it never acks.
    task automatic applyStimulus(input int kind, input logic [15:0] addr,
                                 input logic [7:0] data, input logic [7:0] rdata,
                                 input int delay, input bit early,
                                 input int holdExtra, input bit bothLow,
                                 input bit ackLevel);
        bit   isBus;
        bit   we;
        bit   io;
        bit   tmo;
        int   len;
        reqT  r;
        compT c;

        isBus = (kind <= 3);
        we    = (kind == 1 || kind == 3) && !bothLow;
        io    = (kind == 2 || kind == 3);
        tmo   = (delay > TO);
        len   = tmo ? TO : delay;

        if (isBus) begin
            r.addr  = addr;
            r.we    = we;
            r.io    = io;
            r.wdata = data;
            reqQ.push_back(r);
            if (tmo) begin
                lastDout = 8'hFF;
                errModel = 1'b1;
            end else if (!we) begin
                lastDout = rdata;
            end
            c.len  = len;
            c.dout = lastDout;
            c.doe  = !we;
            c.err  = errModel;
            compQ.push_back(c);
        end else if (kind == 4) begin
            lastDout = data;
            ackQ.push_back(data);
        end

        @(posedge CLK); #1;
        A          = addr;
        D_in       = data;
        int_vector = (kind == 4) ? data : 8'($urandom);
        case (kind)
            0: begin nMREQ = 1'b0; nRD = 1'b0; nM1 = 1'($urandom_range(0, 1)); end
            1: begin nMREQ = 1'b0; nWR = 1'b0; end
            2: begin nIORQ = 1'b0; nRD = 1'b0; end
            3: begin nIORQ = 1'b0; nWR = 1'b0; end
            4: begin nIORQ = 1'b0; nM1 = 1'b0; end
            default: begin nMREQ = 1'b0; nRFSH = 1'b0; end
        endcase
        if (bothLow && isBus) begin
            nRD = 1'b0;
            nWR = 1'b0;
        end

        @(posedge CLK); #1;
        if (isBus) begin
            if (early) releaseStrobes();
            for (int e = 1; e <= len; e++) begin
                if (!tmo && e == delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata;
                end
                @(posedge CLK); #1;
            end
            if (ackLevel && !tmo) begin
                @(posedge CLK); #1;
            end
            bus_ack   = 1'b0;
            bus_rdata = 8'($urandom);
        end
        repeat (holdExtra) begin
            @(posedge CLK); #1;
        end
        releaseStrobes();
        @(posedge CLK); #1;
        checkOutput("doeAfterRelease", D_oe,    0);
        checkOutput("nWaitAfterRelease", nWAIT, 1);
        checkOutput("reqAfterRelease", bus_req, 0);
    endtask

    // Memory read interrupted by reset two cycles into the request.
    task automatic applyResetMidReq(input logic [15:0] addr);
        reqT r;
        r.addr  = addr;
        r.we    = 1'b0;
        r.io    = 1'b0;
        r.wdata = 8'h5A;
        reqQ.push_back(r);
        @(posedge CLK); #1;
        A = addr; D_in = 8'h5A; nMREQ = 1'b0; nRD = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        reset = 1'b1;
        @(posedge CLK); #1;
        checkReset("midReqReset");
        reset = 1'b0;
        releaseStrobes();
        errModel = 1'b0;
        lastDout = 8'h00;
    endtask

    // Monitor: looks at the DUT half a cycle after each active edge. A reset
    // discards everything outstanding. Otherwise a rising bus_req is a new
    // request, a falling bus_req is a completion, and a rising D_oe without
    // a completion is an interrupt vector being returned.
    always @(negedge CLK) begin
        reqT  r;
        compT c;
        if (reset) begin
            reqQ.delete();
            compQ.delete();
            ackQ.delete();
            prevReq = 1'b0;
            prevOe  = 1'b0;
            reqLen  = 0;
        end else begin
            checkOutput("waitTracksReq", nWAIT, !bus_req);
            if (bus_req && !prevReq) begin
                if (reqQ.size() == 0) begin
                    checkOutput("unexpectedReq", 1, 0);
                end else begin
                    r = reqQ.pop_front();
                    checkOutput("bus_addr",  bus_addr,  r.addr);
                    checkOutput("bus_we",    bus_we,    r.we);
                    checkOutput("bus_io",    bus_io,    r.io);
                    checkOutput("bus_wdata", bus_wdata, r.wdata);
                end
            end
            if (bus_req) reqLen++;
            if (!bus_req && prevReq) begin
                if (compQ.size() == 0) begin
                    checkOutput("unexpectedCompletion", 1, 0);
                end else begin
                    c = compQ.pop_front();
                    checkOutput("reqLength",  reqLen,  c.len);
                    checkOutput("doneD_out",  D_out,   c.dout);
                    checkOutput("doneD_oe",   D_oe,    c.doe);
                    checkOutput("doneBusErr", bus_err, c.err);
                end
                reqLen = 0;
            end else if (D_oe && !prevOe) begin
                if (ackQ.size() == 0) begin
                    checkOutput("unexpectedDataDrive", 1, 0);
                end else begin
                    checkOutput("intVector",   D_out, ackQ.pop_front());
                    checkOutput("intAckNoReq", bus_req, 0);
                end
            end
            prevReq = bus_req;
            prevOe  = D_oe;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         kind;
        int         delay;
        int         hold;
        bit         early;
        bit         both;
        bit         lvl;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  rdata;

        reset      = 1'b1;
        releaseStrobes();
        A          = 16'h0000;
        D_in       = 8'h00;
        bus_ack    = 1'b0;
        bus_rdata  = 8'h00;
        int_vector = 8'h00;

        repeat (2) @(posedge CLK);
        #1;
        checkReset("powerOnReset");
        reset = 1'b0;

        $display("[TB] directed cycles");
        applyStimulus(0, 16'h1234, 8'h00, 8'hA5, 3, 0, 1, 0, 0);
        applyStimulus(3, 16'h00FE, 8'h3C, 8'h00, 1, 0, 0, 0, 0);
        applyStimulus(4, 16'h0038, 8'hE7, 8'h00, 0, 0, 2, 0, 0);
        applyStimulus(5, 16'h007F, 8'h00, 8'h00, 0, 0, 1, 0, 0);
        applyStimulus(1, 16'h8000, 8'h99, 8'h00, 2, 0, 0, 0, 0);
        applyStimulus(0, 16'h4000, 8'h00, 8'h5C, 4, 0, 0, 0, 0);
        applyStimulus(2, 16'h0010, 8'h00, 8'h77, 1, 0, 0, 1, 0);
        applyStimulus(0, 16'hBEEF, 8'h00, 8'h00, 5, 0, 0, 0, 0);
        applyStimulus(1, 16'h2000, 8'h11, 8'h00, 2, 0, 0, 0, 1);
        applyStimulus(0, 16'h2001, 8'h00, 8'h22, 1, 0, 0, 0, 0);
        applyResetMidReq(16'h3000);
        applyStimulus(0, 16'h5555, 8'h00, 8'hC3, 3, 1, 0, 0, 0);
        applyStimulus(3, 16'h0001, 8'h42, 8'h00, 6, 1, 0, 0, 0);

        $display("[TB] randomized cycles");
        for (int i = 0; i < 80; i++) begin
            kind  = $urandom_range(0, 5);
            delay = $urandom_range(1, 6);
            hold  = $urandom_range(0, 2);
            early = ($urandom_range(0, 3) == 0);
            both  = ($urandom_range(0, 3) == 0);
            lvl   = ($urandom_range(0, 2) == 0);
            addr  = 16'($urandom);
            data  = 8'($urandom);
            rdata = 8'($urandom);
            applyStimulus(kind, addr, data, rdata, delay, early, hold, both, lvl);
        end

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("queuesDrained", reqQ.size() + compQ.size() + ackQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
